inv_key_schedule: RTL

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

---
 rtl/inv_key_schedule_pkg.sv | 16 +
 rtl/inv_key_schedule_if.sv | 22 ++
 rtl/Sbox.sv | 29 ++
 rtl/inv_key_schedule_step.sv | 38 +++
 rtl/inv_key_schedule.sv | 71 +++++++
 5 files changed

// File: rtl/inv_key_schedule_pkg.sv
// AES-128 constants and state encoding shared by the inverse key schedule.
package aes_pkg;

  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_EMIT = 1'b1;

  // Entry 0 and 11..15 are never used by a legal schedule; padded so any 4-bit index is defined.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage

// File: rtl/inv_key_schedule_if.sv
// Request/stream bundle for the inverse key schedule: master drives start/key_ready,
// slave returns one round key per valid/ready handshake.
interface inv_key_schedule_if;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic         key_valid;
  logic [127:0] key_out;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, key_ready,
    input  key_valid, key_out, round_idx, busy, done
  );

  modport slave (
    input  start, last_key, key_ready,
    output key_valid, key_out, round_idx, busy, done
  );
endinterface

// File: rtl/Sbox.sv
// Forward AES S-box, purely combinational table lookup (entry 0x00 is the MSB byte).
module Sbox (
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry k sits at bit offset (255-k)*8, and 255-k == ~k for an 8-bit k.
  assign sbox_out = SBOX_TBL[{~sbox_in, 3'b000} +: 8];

endmodule

// File: rtl/inv_key_schedule_step.sv
// One combinational inverse key-expansion step: round r key in, round r-1 key out.
module inv_key_schedule_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [3:0]   round_in,
  output logic [127:0] key_prev
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] rot_word;
  logic [31:0] sub_word;

  assign w0 = key_in[127:96];
  assign w1 = key_in[95:64];
  assign w2 = key_in[63:32];
  assign w3 = key_in[31:0];

  assign n3 = w3 ^ w2;
  assign n2 = w2 ^ w1;
  assign n1 = w1 ^ w0;

  // The recovered n3 is exactly the word the forward schedule fed into its g() function.
  assign rot_word = {n3[23:0], n3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    Sbox u_sbox (
      .sbox_in  (rot_word[8*i +: 8]),
      .sbox_out (sub_word[8*i +: 8])
    );
  end

  assign n0 = w0 ^ sub_word ^ {RCON[round_in], 24'h000000};

  assign key_prev = {n0, n1, n2, n3};

endmodule

// File: rtl/inv_key_schedule.sv
// Streams AES-128 round keys 10..0 from the last round key; first key 1 cycle after start,
// one key per cycle while key_ready is high, key_out/round_idx held while key_ready is low.
module inv_key_schedule
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  inv_key_schedule_if.slave     ks
);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic [127:0] key_prev;

  inv_key_schedule_step u_step (
    .key_in   (key_q),
    .round_in (round_q),
    .key_prev (key_prev)
  );

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ks.start) begin
          key_d   = ks.last_key;
          round_d = NUM_ROUNDS;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (ks.key_ready) begin
          if (round_q == 4'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d   = key_prev;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  assign ks.key_valid = (state_q == ST_EMIT);
  assign ks.busy      = (state_q != ST_IDLE);
  assign ks.key_out   = key_q;
  assign ks.round_idx = round_q;
  assign ks.done      = done_q;

endmodule
